// File: rtl/seq_cla_divider.sv
// seq_cla_divider: multi-cycle unsigned restoring divider. It produces one
// quotient bit per clock. Each trial subtraction uses a borrow-lookahead
// subtractor built from 4-bit propagate/generate groups. A start/busy/done
// handshake connects the divider to its requester.
// WIDTH must be a multiple of 4 and at least 4.

module seq_cla_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int NGRP = WIDTH / 4;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // The partial remainder is WIDTH+1 bits only between the shift and the
    // trial subtraction. A restored or subtracted value is always below the
    // divisor, so the stored copy needs only WIDTH bits.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Signals of the trial subtractor: R_shifted + ~{0,D} + 1.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub_a, sub_b, sub_p, sub_g;
    logic [WIDTH-1:0] sub_x;
    logic [WIDTH:0]   carry;
    logic [NGRP-1:0]  grp_p, grp_g;
    logic             carry_out;
    logic [WIDTH-1:0] trial;

    assign r_shift = {r_q, q_q[WIDTH-1]};

    // Borrow-lookahead subtractor: 4-bit lookahead groups chained on group P/G,
    // with the extra top bit resolved by one g|(p&c) stage.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sub_a    = r_shift;
        sub_b    = ~{1'b0, d_q};
        sub_p    = sub_a | sub_b;
        sub_g    = sub_a & sub_b;
        sub_x    = sub_a[WIDTH-1:0] ^ sub_b[WIDTH-1:0];
        grp_p    = '0;
        grp_g    = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int k = 0; k < NGRP; k++) begin
            carry[4*k+1] = sub_g[4*k]
                         | (sub_p[4*k] & carry[4*k]);
            carry[4*k+2] = sub_g[4*k+1]
                         | (sub_p[4*k+1] & sub_g[4*k])
                         | (sub_p[4*k+1] & sub_p[4*k] & carry[4*k]);
            carry[4*k+3] = sub_g[4*k+2]
                         | (sub_p[4*k+2] & sub_g[4*k+1])
                         | (sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k])
                         | (sub_p[4*k+2] & sub_p[4*k+1] & sub_p[4*k] & carry[4*k]);
            grp_p[k]     = sub_p[4*k+3] & sub_p[4*k+2] & sub_p[4*k+1] & sub_p[4*k];
            grp_g[k]     = sub_g[4*k+3]
                         | (sub_p[4*k+3] & sub_g[4*k+2])
                         | (sub_p[4*k+3] & sub_p[4*k+2] & sub_g[4*k+1])
                         | (sub_p[4*k+3] & sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k]);
            carry[4*k+4] = grp_g[k] | (grp_p[k] & carry[4*k]);
        end
        carry_out = sub_g[WIDTH] | (sub_p[WIDTH] & carry[WIDTH]);
        trial     = sub_x ^ carry[WIDTH-1:0];
    end

    // Next-state and datapath update for the IDLE/RUN/DONE control sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = CNT_INIT;
                    dbz_d = 1'b0;
                    if (divisor != '0) begin
                        state_d = RUN;
                    end else begin
                        // Division by zero finishes at once with a saturated quotient.
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                // A carry-out means no borrow: keep the difference. Otherwise restore.
                q_d   = {q_q[WIDTH-2:0], carry_out};
                r_d   = carry_out ? trial : r_shift[WIDTH-1:0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    quo_d   = {q_q[WIDTH-2:0], carry_out};
                    rem_d   = carry_out ? trial : r_shift[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_cla_divider.sv
// Testbench for seq_cla_divider. It covers directed vectors and corner sequences
// at WIDTH=8, plus a random sweep against an arithmetic model at WIDTH=4, 8 and 16.

module tb_seq_cla_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic       start8 = 1'b0;
    logic [7:0] dvd8 = '0, dvs8 = '0;
    logic       busy8, done8, dbz8;
    logic [7:0] quo8, rem8;

    seq_cla_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8),
        .div_by_zero(dbz8)
    );

    // WIDTH = 4 instance
    logic       start4 = 1'b0;
    logic [3:0] dvd4 = '0, dvs4 = '0;
    logic       busy4, done4, dbz4;
    logic [3:0] quo4, rem4;

    seq_cla_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4),
        .div_by_zero(dbz4)
    );

    // WIDTH = 16 instance
    logic        start16 = 1'b0;
    logic [15:0] dvd16 = '0, dvs16 = '0;
    logic        busy16, done16, dbz16;
    logic [15:0] quo16, rem16;

    seq_cla_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .dividend(dvd16), .divisor(dvs16),
        .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16),
        .div_by_zero(dbz16)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: present one start pulse, then release it one cycle later.
    task automatic start8_now(input logic [7:0] a, input logic [7:0] b);
        start8 = 1'b1;
        dvd8   = a;
        dvs8   = b;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    // Starts in cycle 1 after the accepting edge. It counts cycles until done
    // (bounded) and counts the busy cycles seen on the way.
    task automatic wait8(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_div8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
        @(negedge clk);
        start8_now(a, b);
        wait8(lat, bcnt);
    endtask

    task automatic div4(input logic [3:0] a, input logic [3:0] b, output logic ok);
        int n;
        @(negedge clk);
        start4 = 1'b1; dvd4 = a; dvs4 = b;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = done4;
    endtask

    task automatic div16(input logic [15:0] a, input logic [15:0] b, output logic ok);
        int n;
        @(negedge clk);
        start16 = 1'b1; dvd16 = a; dvs16 = b;
        @(negedge clk);
        start16 = 1'b0;
        n = 0;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        ok = done16;
    endtask

    // Reference model: plain integer division. A zero divisor saturates the
    // quotient and returns the dividend as the remainder.
    task automatic check_model(input string tag, input int w, input logic [31:0] a, input logic [31:0] b,
                               input logic ok, input logic [31:0] q, input logic [31:0] r, input logic z);
        logic [31:0] exp_q, exp_r;
        if (b == 0) begin
            exp_q = (32'd1 << w) - 32'd1;
            exp_r = a;
        end else begin
            exp_q = a / b;
            exp_r = a % b;
        end
        check({tag, "_done"}, {31'd0, ok}, 32'd1);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_r"}, r, exp_r);
        check({tag, "_dbz"}, {31'd0, z}, {31'd0, (b == 0)});
        if (b != 0) begin
            check({tag, "_inv"}, q * b + r, a);
            check({tag, "_rltd"}, {31'd0, (r < b)}, 32'd1);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         lat;
        int         busy_cycles;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat, bcnt;
        logic ok;
        logic [31:0] ra, rb;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9, 8};
        vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 8};
        vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 8};
        vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 8};
        vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, 9, 8};
        vecs[5] = '{8'd200, 8'd0,   8'd255, 8'd200, 1'b1, 1, 0};
        vecs[6] = '{8'd10,  8'd3,   8'd3,   8'd1,   1'b0, 9, 8};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_q", {24'd0, quo8}, 32'd0);
        check("rst_r", {24'd0, rem8}, 32'd0);
        check("rst_dbz", {31'd0, dbz8}, 32'd0);
        rst = 1'b0;

        // Directed vectors
        foreach (vecs[i]) begin
            do_div8(vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_busy", i), bcnt, vecs[i].busy_cycles);
            check($sformatf("vec%0d_q", i), {24'd0, quo8}, {24'd0, vecs[i].q});
            check($sformatf("vec%0d_r", i), {24'd0, rem8}, {24'd0, vecs[i].r});
            check($sformatf("vec%0d_dbz", i), {31'd0, dbz8}, {31'd0, vecs[i].z});
        end

        // A start during RUN is ignored. The previous result stays visible until done.
        @(negedge clk);
        start8_now(8'd100, 8'd7);           // now in RUN cycle 1
        repeat (2) @(negedge clk);          // RUN cycle 3
        start8_now(8'd9, 8'd2);             // now in RUN cycle 4
        check("hold_q", {24'd0, quo8}, 32'd3);
        check("hold_r", {24'd0, rem8}, 32'd1);
        wait8(lat, bcnt);
        check("ign_lat", lat, 6);           // cycles 4..9 from this point
        check("ign_q", {24'd0, quo8}, 32'd14);
        check("ign_r", {24'd0, rem8}, 32'd2);

        // Reset in the middle of a division
        @(negedge clk);
        start8_now(8'd100, 8'd7);
        repeat (3) @(negedge clk);          // RUN cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", {31'd0, busy8}, 32'd0);
        check("mrst_done", {31'd0, done8}, 32'd0);
        check("mrst_q", {24'd0, quo8}, 32'd0);
        check("mrst_r", {24'd0, rem8}, 32'd0);
        check("mrst_dbz", {31'd0, dbz8}, 32'd0);
        do_div8(8'd50, 8'd6, lat, bcnt);
        check("mrst_lat", lat, 9);
        check("mrst_q2", {24'd0, quo8}, 32'd8);
        check("mrst_r2", {24'd0, rem8}, 32'd2);

        // Back-to-back: a new start during the done cycle is accepted with no bubble.
        do_div8(8'd77, 8'd5, lat, bcnt);
        check("b2b1_q", {24'd0, quo8}, 32'd15);
        check("b2b1_r", {24'd0, rem8}, 32'd2);
        start8_now(8'd250, 8'd16);          // start held during the done cycle
        check("b2b_busy", {31'd0, busy8}, 32'd1);
        check("b2b_done", {31'd0, done8}, 32'd0);
        wait8(lat, bcnt);
        check("b2b2_lat", lat, 9);
        check("b2b2_q", {24'd0, quo8}, 32'd15);
        check("b2b2_r", {24'd0, rem8}, 32'd10);

        // Random sweep at WIDTH = 8
        for (int i = 0; i < 30; i++) begin
            ra = $urandom & 32'hff;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : ($urandom & 32'hff);
            do_div8(ra[7:0], rb[7:0], lat, bcnt);
            check_model("w8", 8, ra, rb, done8, {24'd0, quo8}, {24'd0, rem8}, dbz8);
        end

        // Random sweep at WIDTH = 4
        for (int i = 0; i < 30; i++) begin
            ra = $urandom & 32'hf;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & 32'hf);
            div4(ra[3:0], rb[3:0], ok);
            check_model("w4", 4, ra, rb, ok, {28'd0, quo4}, {28'd0, rem4}, dbz4);
        end

        // Random sweep at WIDTH = 16
        for (int i = 0; i < 30; i++) begin
            ra = $urandom & 32'hffff;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 255) : ($urandom & 32'hffff);
            div16(ra[15:0], rb[15:0], ok);
            check_model("w16", 16, ra, rb, ok, {16'd0, quo16}, {16'd0, rem16}, dbz16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
